mem_filter_pingpong: RTL

//  Double-buffered (ping-pong) filter store for the sparse conv datapath. Filter chunks
//  (sparsemap + nonzero bytes) stream in as BUS_SIZE-wide beats into one bank while the PE

---
 rtl/npu_filter_pkg.sv | 16 +
 rtl/mem_filter_bank.sv | 31 +++
 rtl/mem_filter_pingpong.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/npu_filter_pkg.sv
// Shared defaults and the beat record for the ping-pong filter store.
package npu_filter_pkg;

    localparam int BUS_SIZE   = 32;
    localparam int CHUNK_SIZE = 128;
    localparam int FILTER_NUM = 4;
    localparam int DATA_W     = 8;
    localparam int BEATS      = CHUNK_SIZE / BUS_SIZE;

    // One bus beat: sparsemap slice plus the matching nonzero bytes.
    typedef struct packed {
        logic [BUS_SIZE-1:0]             map;
        logic [BUS_SIZE-1:0][DATA_W-1:0] nz;
    } beat_t;

endpackage

// File: rtl/mem_filter_bank.sv
// One bank of filter storage: synchronous write, combinational read.
// Contents are never cleared; the top-level full flags gate every read.
module mem_filter_bank
    import npu_filter_pkg::*;
#(
    parameter int  N_CHUNK = FILTER_NUM,
    parameter int  N_BEAT  = BEATS,
    parameter int  CW      = (N_CHUNK > 1) ? $clog2(N_CHUNK) : 1,
    parameter int  BW      = (N_BEAT > 1) ? $clog2(N_BEAT) : 1,
    parameter type BEAT_T  = beat_t
) (
    input  logic          clk,
    input  logic          we,
    input  logic [CW-1:0] wr_chunk,
    input  logic [BW-1:0] wr_beat,
    input  BEAT_T         wr_data,
    input  logic [CW-1:0] rd_chunk,
    input  logic [BW-1:0] rd_beat,
    output BEAT_T         rd_data
);

    BEAT_T mem [N_CHUNK][N_BEAT];

    // Store one accepted beat at its chunk/beat slot.
    always_ff @(posedge clk) begin
        if (we) mem[wr_chunk][wr_beat] <= wr_data;
    end

    assign rd_data = mem[rd_chunk][rd_beat];

endmodule

// File: rtl/mem_filter_pingpong.sv
// Ping-pong filter store: one bank fills from the bus while the PE array
// reads the other. Holds the fill counters, full flags, bank pointers and
// the registered read port with its popcount.
module mem_filter_pingpong #(
    parameter int BUS_SIZE   = npu_filter_pkg::BUS_SIZE,
    parameter int CHUNK_SIZE = npu_filter_pkg::CHUNK_SIZE,
    parameter int FILTER_NUM = npu_filter_pkg::FILTER_NUM,
    parameter int DATA_W     = npu_filter_pkg::DATA_W,
    localparam int BEATS     = CHUNK_SIZE / BUS_SIZE,
    localparam int BW        = (BEATS > 1) ? $clog2(BEATS) : 1,
    localparam int CW        = (FILTER_NUM > 1) ? $clog2(FILTER_NUM) : 1,
    localparam int NCW       = $clog2(BUS_SIZE + 1)
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       wr_valid_i,
    output logic                       wr_ready_o,
    input  logic [BUS_SIZE-1:0]        wr_sparsemap_i,
    input  logic [BUS_SIZE*DATA_W-1:0] wr_nonzero_data_i,
    output logic                       wr_bank_o,
    input  logic                       rd_req_i,
    input  logic [CW-1:0]              rd_chunk_i,
    input  logic [BW-1:0]              rd_beat_i,
    output logic                       rd_valid_o,
    output logic [BUS_SIZE-1:0]        rd_sparsemap_o,
    output logic [BUS_SIZE*DATA_W-1:0] rd_nonzero_data_o,
    output logic [NCW-1:0]             rd_nz_cnt_o,
    output logic                       rd_bank_ready_o,
    input  logic                       rd_release_i,
    output logic [1:0]                 bank_full_o
);

    // Local copy of the beat record so non-default widths still line up.
    typedef struct packed {
        logic [BUS_SIZE-1:0]             map;
        logic [BUS_SIZE-1:0][DATA_W-1:0] nz;
    } beat_t;

    logic [1:0]     full, full_nxt;
    logic           wr_bank, rd_bank;
    logic [BW-1:0]  wr_beat;
    logic [CW-1:0]  wr_chunk;
    logic           wr_fire, wr_beat_last, wr_last, rd_fire, rel_fire;
    beat_t          wr_data, rd_sel;
    beat_t [1:0]    bank_rd;
    logic [NCW-1:0] nz_cnt;

    assign wr_ready_o      = !full[wr_bank];
    assign rd_bank_ready_o = full[rd_bank];
    assign bank_full_o     = full;
    assign wr_bank_o       = wr_bank;

    assign wr_fire      = wr_valid_i && wr_ready_o;
    assign wr_beat_last = (wr_beat == BW'(BEATS - 1));
    assign wr_last      = wr_fire && wr_beat_last && (wr_chunk == CW'(FILTER_NUM - 1));
    assign rd_fire      = rd_req_i && full[rd_bank];
    assign rel_fire     = rd_release_i && full[rd_bank];

    assign wr_data.map = wr_sparsemap_i;
    assign wr_data.nz  = wr_nonzero_data_i;

    for (genvar b = 0; b < 2; b++) begin : g_bank
        mem_filter_bank #(
            .N_CHUNK (FILTER_NUM),
            .N_BEAT  (BEATS),
            .CW      (CW),
            .BW      (BW),
            .BEAT_T  (beat_t)
        ) u_bank (
            .clk      (clk_i),
            .we       (wr_fire && (wr_bank == 1'(b))),
            .wr_chunk (wr_chunk),
            .wr_beat  (wr_beat),
            .wr_data  (wr_data),
            .rd_chunk (rd_chunk_i),
            .rd_beat  (rd_beat_i),
            .rd_data  (bank_rd[b])
        );
    end

    // Read comes from the current read bank, sampled before any release moves it.
    assign rd_sel = bank_rd[rd_bank];

    // Popcount of the selected sparsemap beat.
    always_comb begin
        nz_cnt = '0;
        for (int i = 0; i < BUS_SIZE; i++) nz_cnt = nz_cnt + NCW'(rd_sel.map[i]);
    end

    // Fill-complete and release always target different banks, so both apply.
    always_comb begin
        full_nxt = full;
        if (wr_last)  full_nxt[wr_bank] = 1'b1;
        if (rel_fire) full_nxt[rd_bank] = 1'b0;
    end

    // Flags, bank pointers and self-counting write address.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            full     <= '0;
            wr_bank  <= 1'b0;
            rd_bank  <= 1'b0;
            wr_beat  <= '0;
            wr_chunk <= '0;
        end else begin
            full <= full_nxt;
            if (rel_fire) rd_bank <= ~rd_bank;
            if (wr_fire) begin
                if (wr_beat_last) begin
                    wr_beat <= '0;
                    if (wr_chunk == CW'(FILTER_NUM - 1)) begin
                        wr_chunk <= '0;
                        wr_bank  <= ~wr_bank;
                    end else begin
                        wr_chunk <= wr_chunk + 1'b1;
                    end
                end else begin
                    wr_beat <= wr_beat + 1'b1;
                end
            end
        end
    end

    // Registered read port; data holds when no request is accepted.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rd_valid_o        <= 1'b0;
            rd_sparsemap_o    <= '0;
            rd_nonzero_data_o <= '0;
            rd_nz_cnt_o       <= '0;
        end else begin
            rd_valid_o <= rd_fire;
            if (rd_fire) begin
                rd_sparsemap_o    <= rd_sel.map;
                rd_nonzero_data_o <= rd_sel.nz;
                rd_nz_cnt_o       <= nz_cnt;
            end
        end
    end

endmodule
